// File: rtl/ahb_mem_slave_v2_if.sv
// AHB-Lite bus bundle for ahb_mem_slave_v2.
// Carries the address/control phase signals (hsel, haddr, hwrite, hsize,
// hburst, htrans, hready), write data (hwdata), and the slave response
// (hreadyout, hresp, hrdata). The master modport drives the request side and
// the slave modport drives the response side.
interface ahb_mem_slave_v2_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [1:0]        htrans;
  logic              hready;
  logic [DATA_W-1:0] hwdata;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, hwrite, hsize, hburst, htrans, hready, hwdata,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hwrite, hsize, hburst, htrans, hready, hwdata,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_mem_slave_v2.sv
// AHB-Lite memory slave with configurable width, depth and wait states.
// Out-of-range addresses get a two-cycle ERROR response. A snapshot port
// captures one memory word for the display path when confirm rises.
// Ports:
//   hclk, hresetn      clock, synchronous active-low reset
//   bus (slave)        AHB-Lite request/response bundle
//   disp_sel           word index to snapshot
//   confirm            asynchronous capture request (synchronised here)
//   snap_q, snap_valid captured word and "a capture has happened" flag
module ahb_mem_slave_v2 #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  ahb_mem_slave_v2_if.slave     bus,
  input  logic [ADDR_W-1:0]     disp_sel,
  input  logic                  confirm,
  output logic [DATA_W-1:0]     snap_q,
  output logic                  snap_valid
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {ST_OKAY, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;       // in-range data phase outstanding
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              edge_q, edge_d;
  logic [DATA_W-1:0] snap_data_q, snap_data_d;
  logic              snap_valid_q, snap_valid_d;

  logic accept_s;
  logic oor_s;
  logic mem_we_s;
  logic snap_edge_s;
  logic unused_s;

  // Transfer size and burst type carry no information for this slave.
  assign unused_s = ^{bus.hsize, bus.hburst, bus.htrans[0]};

  // Next-state, data-path and snapshot logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    addr_d       = addr_q;
    write_d      = write_q;
    hrdata_d     = hrdata_q;
    sync1_d      = confirm;
    sync2_d      = sync1_q;
    edge_d       = sync2_q;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;

    // Only OKAY and ERR2 drive hreadyout high, so only they can take a new address.
    accept_s = bus.hsel & bus.hready & bus.htrans[1] & hreadyout_q;
    oor_s    = ({1'b0, bus.haddr} >= DEPTH_X);
    // A pending in-range data phase completes whenever the FSM sits in OKAY.
    mem_we_s = (state_q == ST_OKAY) & pend_q & write_q;

    case (state_q)
      ST_OKAY, ST_ERR2: begin
        state_d = ST_OKAY;
        pend_d  = 1'b0;
        if (accept_s) begin
          addr_d  = bus.haddr;
          write_d = bus.hwrite;
          if (oor_s) begin
            state_d  = ST_ERR1;
            hrdata_d = {DATA_W{1'b0}};
          end else begin
            pend_d = 1'b1;
            if (WAIT_STATES == 0) begin
              // Zero-wait read: data is loaded now, forwarding a write completing on this edge.
              if (!bus.hwrite) begin
                if (mem_we_s && (addr_q == bus.haddr)) begin
                  hrdata_d = bus.hwdata;
                end else begin
                  hrdata_d = mem[bus.haddr[IDX_W-1:0]];
                end
              end else begin
                hrdata_d = hrdata_q;
              end
            end else begin
              state_d = ST_WAIT;
              cnt_d   = 3'(WAIT_STATES);
            end
          end
        end else begin
          addr_d = addr_q;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = ST_OKAY;
          // Load read data so it is valid in the final (ready) data-phase cycle.
          if (!write_q) begin
            hrdata_d = mem[addr_q[IDX_W-1:0]];
          end else begin
            hrdata_d = hrdata_q;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_OKAY;
      end
    endcase

    hreadyout_d = (state_d == ST_OKAY) || (state_d == ST_ERR2);
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);

    snap_edge_s = sync2_q & ~edge_q;
    if (snap_edge_s) begin
      snap_valid_d = 1'b1;
      if ({1'b0, disp_sel} < DEPTH_X) begin
        if (mem_we_s && (addr_q == disp_sel)) begin
          snap_data_d = bus.hwdata;
        end else begin
          snap_data_d = mem[disp_sel[IDX_W-1:0]];
        end
      end else begin
        snap_data_d = {DATA_W{1'b0}};
      end
    end else begin
      snap_data_d = snap_data_q;
    end
  end

  // Control, response and snapshot registers with synchronous reset.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q      <= ST_OKAY;
      cnt_q        <= 3'd0;
      pend_q       <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      write_q      <= 1'b0;
      hrdata_q     <= {DATA_W{1'b0}};
      hreadyout_q  <= 1'b1;
      hresp_q      <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      edge_q       <= 1'b0;
      snap_data_q  <= {DATA_W{1'b0}};
      snap_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      hrdata_q     <= hrdata_d;
      hreadyout_q  <= hreadyout_d;
      hresp_q      <= hresp_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      edge_q       <= edge_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  // Memory array: contents survive reset, but a write is dropped on a reset edge.
  always_ff @(posedge hclk) begin
    if (hresetn && mem_we_s) begin
      mem[addr_q[IDX_W-1:0]] <= bus.hwdata;
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;
  assign snap_q        = snap_data_q;
  assign snap_valid    = snap_valid_q;

endmodule

// File: tb/tb_ahb_mem_slave_v2.sv
// Testbench for ahb_mem_slave_v2: three instances (WAIT_STATES 0, 2, 3),
// table-driven vectors, hand-written corner sequences and random transfers
// checked against a word-level memory model.
module tb_ahb_mem_slave_v2;

  logic       hclk;
  logic       hresetn_v [3];
  logic       hsel_v    [3];
  logic [9:0] haddr_v   [3];
  logic       hwrite_v  [3];
  logic [1:0] htrans_v  [3];
  logic [7:0] hwdata_v  [3];
  logic       hrdy_v    [3];
  logic       hresp_v   [3];
  logic [7:0] hrdata_v  [3];
  logic [9:0] disp_v    [3];
  logic       conf_v    [3];
  logic [7:0] snap_v    [3];
  logic       sval_v    [3];

  int tests = 0;
  int fails = 0;
  logic [7:0] model [3][64];

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    ahb_mem_slave_v2_if #(.DATA_W(8), .ADDR_W(10)) bus ();
    assign bus.hsel   = hsel_v[g];
    assign bus.haddr  = haddr_v[g];
    assign bus.hwrite = hwrite_v[g];
    assign bus.hsize  = 3'd0;
    assign bus.hburst = 3'd1;
    assign bus.htrans = htrans_v[g];
    assign bus.hready = bus.hreadyout;
    assign bus.hwdata = hwdata_v[g];
    assign hrdy_v[g]   = bus.hreadyout;
    assign hresp_v[g]  = bus.hresp;
    assign hrdata_v[g] = bus.hrdata;
    ahb_mem_slave_v2 #(.DATA_W(8), .ADDR_W(10), .DEPTH(64), .WAIT_STATES(WS)) u_dut (
      .hclk       (hclk),
      .hresetn    (hresetn_v[g]),
      .bus        (bus),
      .disp_sel   (disp_v[g]),
      .confirm    (conf_v[g]),
      .snap_q     (snap_v[g]),
      .snap_valid (sval_v[g])
    );
  end

  typedef struct {
    int         k;
    bit         wr;
    int         addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    int         exp_cyc;
    bit         exp_err;
  } vec_t;

  vec_t tv [$];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic logic [7:0] pre(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // One non-pipelined transfer: address phase, then data phase until ready.
  task automatic xfer(input int k, input bit wr, input int a, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input int exp_cyc, input bit exp_err,
                      input string nm);
    int cyc;
    bit resp_bad;
    logic [7:0] rd;
    hsel_v[k] = 1'b1; htrans_v[k] = 2'b10; haddr_v[k] = 10'(a); hwrite_v[k] = wr;
    tick();
    hsel_v[k] = 1'b0; htrans_v[k] = 2'b00; hwdata_v[k] = wd;
    cyc = 0; resp_bad = 1'b0;
    while (1) begin
      cyc++;
      if (hresp_v[k] !== exp_err) resp_bad = 1'b1;
      if (hrdy_v[k] === 1'b1 || cyc >= 20) break;
      tick();
    end
    rd = hrdata_v[k];
    chk({nm, " cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({nm, " hresp_bad"}, 32'(resp_bad), 32'd0);
    if (!wr || exp_err) chk({nm, " hrdata"}, 32'(rd), 32'(exp_rd));
    tick();
    if (wr && !exp_err) model[k][a] = wd;
  endtask

  // Transfer whose expectations come from the reference model.
  task automatic mxfer(input int k, input bit wr, input int a, input logic [7:0] wd, input string nm);
    bit err;
    err = (a >= 64);
    xfer(k, wr, a, wd, err ? 8'h00 : model[k][a], err ? 2 : ws_of(k) + 1, err, nm);
  endtask

  initial begin
    int tr [8];
    int ad [8];
    for (int k = 0; k < 3; k++) begin
      hresetn_v[k] = 1'b0; hsel_v[k] = 1'b0; haddr_v[k] = 10'd0; hwrite_v[k] = 1'b0;
      htrans_v[k] = 2'b00; hwdata_v[k] = 8'h00; disp_v[k] = 10'd0; conf_v[k] = 1'b0;
    end
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      chk("reset hreadyout", 32'(hrdy_v[k]), 32'd1);
      chk("reset hresp", 32'(hresp_v[k]), 32'd0);
      chk("reset hrdata", 32'(hrdata_v[k]), 32'd0);
      chk("reset snap_q", 32'(snap_v[k]), 32'd0);
      chk("reset snap_valid", 32'(sval_v[k]), 32'd0);
      hresetn_v[k] = 1'b1;
    end
    tick();

    // Snapshot first on dut0 so snap_valid rises from its reset value.
    xfer(0, 1'b1, 5, 8'h12, 8'h00, 1, 1'b0, "snap wr5");
    disp_v[0] = 10'd5; conf_v[0] = 1'b1;
    tick(); tick();
    chk("snap edge2 valid", 32'(sval_v[0]), 32'd0);
    chk("snap edge2 data", 32'(snap_v[0]), 32'd0);
    tick();
    chk("snap edge3 valid", 32'(sval_v[0]), 32'd1);
    chk("snap edge3 data", 32'(snap_v[0]), 32'h12);
    xfer(0, 1'b1, 5, 8'h34, 8'h00, 1, 1'b0, "snap wr5b");
    for (int i = 0; i < 6; i++) tick();
    chk("snap held single capture", 32'(snap_v[0]), 32'h12);
    conf_v[0] = 1'b0; tick(); tick(); tick();
    disp_v[0] = 10'd100; conf_v[0] = 1'b1;
    tick(); tick(); tick();
    chk("snap oor data", 32'(snap_v[0]), 32'd0);
    chk("snap oor valid", 32'(sval_v[0]), 32'd1);
    conf_v[0] = 1'b0; tick(); tick(); tick();
    disp_v[0] = 10'd5; conf_v[0] = 1'b1;
    tick(); tick(); tick();
    chk("snap recapture", 32'(snap_v[0]), 32'h34);
    conf_v[0] = 1'b0;

    // Preload every word so the model is fully known.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++)
        xfer(k, 1'b1, i, pre(i), 8'h00, ws_of(k) + 1, 1'b0, "preload");

    tv.push_back('{1, 1'b1, 10,   8'h3C, 8'h00, 3, 1'b0});
    tv.push_back('{1, 1'b0, 10,   8'h00, 8'h3C, 3, 1'b0});
    tv.push_back('{0, 1'b1, 70,   8'hFF, 8'h00, 2, 1'b1});
    tv.push_back('{0, 1'b0, 6,    8'h00, 8'hE9, 1, 1'b0});
    tv.push_back('{1, 1'b1, 70,   8'hFF, 8'h00, 2, 1'b1});
    tv.push_back('{1, 1'b0, 6,    8'h00, 8'hE9, 3, 1'b0});
    tv.push_back('{0, 1'b0, 63,   8'h00, 8'h26, 1, 1'b0});
    tv.push_back('{0, 1'b0, 64,   8'h00, 8'h00, 2, 1'b1});
    tv.push_back('{2, 1'b1, 8,    8'h81, 8'h00, 4, 1'b0});
    tv.push_back('{2, 1'b0, 8,    8'h00, 8'h81, 4, 1'b0});
    tv.push_back('{2, 1'b0, 1023, 8'h00, 8'h00, 2, 1'b1});
    tv.push_back('{2, 1'b1, 0,    8'h5A, 8'h00, 4, 1'b0});
    tv.push_back('{2, 1'b0, 0,    8'h00, 8'h5A, 4, 1'b0});
    foreach (tv[i])
      xfer(tv[i].k, tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].exp_rd,
           tv[i].exp_cyc, tv[i].exp_err, $sformatf("vec%0d", i));

    // Back-to-back write then read of the same word on dut0 (forwarding).
    hsel_v[0] = 1'b1; htrans_v[0] = 2'b10; haddr_v[0] = 10'd3; hwrite_v[0] = 1'b1;
    tick();
    hwdata_v[0] = 8'hA5; hwrite_v[0] = 1'b0;
    chk("b2b write dphase ready", 32'(hrdy_v[0]), 32'd1);
    tick();
    hsel_v[0] = 1'b0; htrans_v[0] = 2'b00;
    chk("b2b read dphase ready", 32'(hrdy_v[0]), 32'd1);
    chk("b2b forwarded hrdata", 32'(hrdata_v[0]), 32'hA5);
    tick();
    model[0][3] = 8'hA5;

    // Reset during a WAIT cycle of a write on dut2.
    mxfer(2, 1'b0, 8, 8'h00, "rst preread");
    hsel_v[2] = 1'b1; htrans_v[2] = 2'b10; haddr_v[2] = 10'd8; hwrite_v[2] = 1'b1;
    tick();
    chk("rst wait hreadyout", 32'(hrdy_v[2]), 32'd0);
    hsel_v[2] = 1'b0; htrans_v[2] = 2'b00; hwdata_v[2] = 8'h99; hresetn_v[2] = 1'b0;
    tick();
    chk("rst hreadyout", 32'(hrdy_v[2]), 32'd1);
    chk("rst hresp", 32'(hresp_v[2]), 32'd0);
    chk("rst hrdata", 32'(hrdata_v[2]), 32'd0);
    chk("rst snap_valid", 32'(sval_v[2]), 32'd0);
    hresetn_v[2] = 1'b1;
    tick();
    mxfer(2, 1'b0, 8, 8'h00, "rst addr8 kept");

    // INCR burst on dut0 with BUSY and IDLE interleaved.
    tr = '{2, 1, 3, 0, 3, 1, 3, 0};
    ad = '{0, 0, 1, 1, 2, 2, 3, 3};
    for (int i = 0; i <= 8; i++) begin
      hsel_v[0] = 1'b1; hwrite_v[0] = 1'b1;
      htrans_v[0] = (i < 8) ? 2'(tr[i]) : 2'b00;
      haddr_v[0]  = (i < 8) ? 10'(ad[i]) : 10'd0;
      hwdata_v[0] = (i > 0 && tr[i-1] >= 2) ? 8'(8'hB0 + ad[i-1]) : 8'h00;
      if (i > 0) begin
        chk($sformatf("burst cyc%0d ready", i), 32'(hrdy_v[0]), 32'd1);
        chk($sformatf("burst cyc%0d hresp", i), 32'(hresp_v[0]), 32'd0);
      end
      tick();
    end
    hsel_v[0] = 1'b0; htrans_v[0] = 2'b00;
    for (int i = 0; i < 4; i++) model[0][i] = 8'(8'hB0 + i);
    for (int i = 0; i < 4; i++) mxfer(0, 1'b0, i, 8'h00, $sformatf("burst rd%0d", i));

    // Random transfers against the model.
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 120; n++)
        mxfer(k, 1'($urandom_range(1, 0)), int'($urandom_range(79, 0)),
              8'($urandom_range(255, 0)), $sformatf("rand k%0d n%0d", k, n));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
